// File: rtl/video_timing_detect.sv
// Sink-side video timing recovery: rebuilds hc/vc from hsync/vsync/hbl/vbl,
// measures line/frame geometry and sync placement, and flags lock once the geometry is stable.
module video_timing_detect #(
  parameter int W           = 9,
  parameter int LOCK_FRAMES = 3,
  parameter int SYNC_LOW    = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_pix,
  input  logic         hsync,
  input  logic         vsync,
  input  logic         hbl,
  input  logic         vbl,
  output logic [W-1:0] hc,
  output logic [W-1:0] vc,
  output logic [W-1:0] h_total,
  output logic [W-1:0] h_active,
  output logic [W-1:0] hs_pos,
  output logic [W-1:0] hs_width,
  output logic [W-1:0] v_total,
  output logic [W-1:0] v_active,
  output logic [W-1:0] vs_pos,
  output logic [W-1:0] vs_width,
  output logic         frame_start,
  output logic         locked,
  output logic         timeout
);

  localparam logic [W-1:0] MAX    = {W{1'b1}};
  localparam logic [W-1:0] ONE    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [3:0]   LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;
  state_t state, state_n;

  logic [1:0]   rst_q;
  logic         rst;
  logic         hs, vs;
  logic         hs_d, vs_d, hbl_d, vbl_d;
  logic         hbl_fall, hbl_rise, vbl_fall, vbl_rise;
  logic         hs_rise, hs_fall, vs_rise, vs_fall;
  logic [W-1:0] hcnt, vcnt, h_new, v_new, hidx, vidx;
  logic [W-1:0] ref_h, ref_v;
  logic [3:0]   match, match_inc;
  logic         sat, geo_ok, line_bad, skip;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == MAX) ? MAX : v + ONE;
  endfunction

  // Reset asserts asynchronously, releases two clocks later in step with clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_q <= 2'b11;
    else       rst_q <= {rst_q[0], 1'b0};
  end
  assign rst = rst_q[1];

  assign hs = (SYNC_LOW != 0) ? ~hsync : hsync;
  assign vs = (SYNC_LOW != 0) ? ~vsync : vsync;

  assign hbl_fall = clk_pix &  hbl_d & ~hbl;
  assign hbl_rise = clk_pix & ~hbl_d &  hbl;
  assign vbl_fall = clk_pix &  vbl_d & ~vbl;
  assign vbl_rise = clk_pix & ~vbl_d &  vbl;
  assign hs_rise  = clk_pix & ~hs_d  &  hs;
  assign hs_fall  = clk_pix &  hs_d  & ~hs;
  assign vs_rise  = clk_pix & ~vs_d  &  vs;
  assign vs_fall  = clk_pix &  vs_d  & ~vs;

  // hidx/vidx are the position of the sample being observed this enable, so
  // edges are stamped with the pixel/line on which they actually occur.
  assign h_new = sat_inc(hcnt);
  assign v_new = sat_inc(vcnt);
  assign hidx  = hbl_fall ? '0 : h_new;
  assign vidx  = vbl_fall ? '0 : (hbl_fall ? v_new : vcnt);

  // A counter about to be cleared by its own edge does not count as saturated.
  assign sat       = ((hcnt == MAX) && !hbl_fall) || ((vcnt == MAX) && !vbl_fall);
  assign geo_ok    = (h_new == ref_h) && (v_new == ref_v) && !line_bad;
  assign match_inc = match + 4'd1;

  assign hc = hcnt;
  assign vc = vcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_d <= 1'b0; vs_d <= 1'b0; hbl_d <= 1'b0; vbl_d <= 1'b0;
      hcnt <= '0; vcnt <= '0;
      h_total <= '0; h_active <= '0; hs_pos <= '0; hs_width <= '0;
      v_total <= '0; v_active <= '0; vs_pos <= '0; vs_width <= '0;
      frame_start <= 1'b0;
    end else begin
      if (clk_pix) begin
        hs_d  <= hs;
        vs_d  <= vs;
        hbl_d <= hbl;
        vbl_d <= vbl;
        hcnt  <= hidx;
        vcnt  <= vidx;
      end
      if (hbl_fall) h_total  <= h_new;
      if (hbl_rise) h_active <= hidx;
      if (hs_rise)  hs_pos   <= hidx;
      if (hs_fall)  hs_width <= hidx - hs_pos;
      if (vbl_fall) v_total  <= v_new;
      if (vbl_rise) v_active <= vidx;
      if (vs_rise)  vs_pos   <= vidx;
      if (vs_fall)  vs_width <= vidx - vs_pos;
      frame_start <= vbl_fall;
    end
  end

  // Lock bookkeeping: references, match count, intra-frame line check, timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout  <= 1'b0;
      line_bad <= 1'b0;
      skip     <= 1'b1;
      match    <= '0;
      ref_h    <= '0;
      ref_v    <= '0;
    end else begin
      if (sat)           timeout <= 1'b1;
      else if (vbl_fall) timeout <= 1'b0;

      if (vbl_fall)                                       line_bad <= 1'b0;
      else if (hbl_fall && !skip && (h_new != h_total))   line_bad <= 1'b1;

      if (state == SEARCH)            skip <= 1'b1;
      else if (hbl_fall && !vbl_fall) skip <= 1'b0;

      if (sat) begin
        match <= '0;
      end else if (vbl_fall) begin
        case (state)
          SEARCH: begin
            match <= '0;
            ref_h <= h_new;
            ref_v <= v_new;
          end
          TRACK: begin
            if (geo_ok) begin
              match <= match_inc;
            end else begin
              match <= '0;
              ref_h <= h_new;
              ref_v <= v_new;
            end
          end
          default: begin
            if (!geo_ok) begin
              match <= '0;
              ref_h <= h_new;
              ref_v <= v_new;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEARCH;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (sat) begin
      state_n = SEARCH;
    end else if (vbl_fall) begin
      case (state)
        SEARCH:  state_n = TRACK;
        TRACK:   if (geo_ok && (match_inc == LOCK_N)) state_n = LOCKED;
        LOCKED:  if (!geo_ok) state_n = SEARCH;
        default: state_n = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

endmodule
